// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner arbiter for the shared 4-digit 7-segment display
//
// Purpose: time-shares the single hex display between NUM_SRC requesters.
//   A granted source stays on the display for DWELL cycles. Before a different
//   source is shown, the display is blanked for GAP cycles.
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high
//   req         per-source display request (level)
//   data        source i value at data[16*i+15:16*i]
//   hold        freezes dwell/gap counting
//   grant       one-hot display owner, all-zero when none
//   disp_value  value for the seg driver ([15:12] leftmost digit)
//   disp_blank  1 = all digits off
module seg_display_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DWELL   = 4194304,
  parameter int GAP     = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [16*NUM_SRC-1:0]  data,
  input  logic                   hold,
  output logic [NUM_SRC-1:0]     grant,
  output logic [15:0]            disp_value,
  output logic                   disp_blank
);

  localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int PW      = $clog2(NUM_SRC);

  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP - 1);
  localparam logic [PW-1:0] PTR_INIT   = PW'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [PW-1:0]       ptr, ptr_n;
  logic [NUM_SRC-1:0]  grant_n;
  logic [15:0]         value_n;
  logic                blank_n;

  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [NUM_SRC-1:0]  win_onehot;
  logic [15:0]         sel_data;
  logic                own_req;
  logic                other_req;

  // Round-robin search: sources above the pointer first, then wrap to 0..ptr.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && req[i] && (i > int'(ptr))) begin
        win_found     = 1'b1;
        win_idx       = PW'(i);
        win_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && req[i] && (i <= int'(ptr))) begin
        win_found     = 1'b1;
        win_idx       = PW'(i);
        win_onehot[i] = 1'b1;
      end
    end
  end

  // grant is one-hot, so OR-ing the masked slices picks the owner's value.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | data[16*i +: 16];
      end
    end
  end

  assign own_req   = |(req & grant);
  assign other_req = |(req & ~grant);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= PTR_INIT;
      grant      <= '0;
      disp_value <= '0;
      disp_blank <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ptr        <= ptr_n;
      grant      <= grant_n;
      disp_value <= value_n;
      disp_blank <= blank_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    grant_n = grant;
    value_n = disp_value;
    blank_n = disp_blank;

    unique case (state)
      S_IDLE: begin
        grant_n = '0;
        blank_n = 1'b1;
        if (win_found) begin
          state_n = S_SHOW;
          ptr_n   = win_idx;
          grant_n = win_onehot;
          blank_n = 1'b0;
          cnt_n   = DWELL_LOAD;
        end
      end

      S_SHOW: begin
        value_n = sel_data;
        // A dropped request ends the turn even while hold is set, and
        // takes priority over a simultaneous dwell expiry.
        if (!own_req) begin
          state_n = S_GAP;
          grant_n = '0;
          blank_n = 1'b1;
          cnt_n   = GAP_LOAD;
        end else if (!hold) begin
          if (cnt == '0) begin
            if (other_req) begin
              state_n = S_GAP;
              grant_n = '0;
              blank_n = 1'b1;
              cnt_n   = GAP_LOAD;
            end else begin
              cnt_n = DWELL_LOAD;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end

      S_GAP: begin
        grant_n = '0;
        blank_n = 1'b1;
        if (!hold) begin
          if (cnt == '0) begin
            if (win_found) begin
              state_n = S_SHOW;
              ptr_n   = win_idx;
              grant_n = win_onehot;
              blank_n = 1'b0;
              cnt_n   = DWELL_LOAD;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        grant_n = '0;
        blank_n = 1'b1;
      end
    endcase
  end

endmodule
